// File: rtl/cordic_pkg.sv
// Shared definitions for the pipelined CORDIC: mode encodings, arctangent
// table and width helpers.
package cordic_pkg;

  localparam int MAX_STAGES = 20;

  typedef enum logic {
    ROT = 1'b0,
    VEC = 1'b1
  } mode_e;

  function automatic int iw_of(input int dat_w);
    return dat_w + 2;
  endfunction

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32.
  function automatic longint atan32(input int i);
    case (i)
      0:  return 32'h2000_0000;
      1:  return 32'h12E4_051E;
      2:  return 32'h09FB_385B;
      3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;
      5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;
      7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;
      9:  return 32'h0014_5F2F;
      10: return 32'h000A_2F98;
      11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;
      13: return 32'h0001_45F3;
      14: return 32'h0000_A2FA;
      15: return 32'h0000_517D;
      16: return 32'h0000_28BE;
      17: return 32'h0000_145F;
      18: return 32'h0000_0A30;
      19: return 32'h0000_0518;
      default: return 0;
    endcase
  endfunction

  // Round the 32-bit turn fraction down to ANG_W bits.
  function automatic int atan_val(input int ang_w, input int i);
    if (ang_w >= 32) return int'(atan32(i));
    return int'((atan32(i) + (64'sd1 <<< (31 - ang_w))) >>> (32 - ang_w));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; valid and mode ride along so each
// sample is steered by its own mode bit.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int IW       = 18,
  parameter int ANG_W    = 16,
  parameter int SHIFT    = 0,
  parameter int ATAN_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    val,
  input  logic                    mode,
  input  logic signed [IW-1:0]    x,
  input  logic signed [IW-1:0]    y,
  input  logic signed [ANG_W-1:0] z,
  output logic                    val_reg,
  output logic                    mode_reg,
  output logic signed [IW-1:0]    x_reg,
  output logic signed [IW-1:0]    y_reg,
  output logic signed [ANG_W-1:0] z_reg
);

  localparam logic signed [ANG_W-1:0] ATAN_C = ANG_W'(ATAN_VAL);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;
  logic                 pos;

  assign x_sh = x >>> SHIFT;
  assign y_sh = y >>> SHIFT;
  // d = +1: rotation drives z toward zero, vectoring drives y toward zero
  assign pos  = (mode == VEC) ? y[IW-1] : ~z[ANG_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_reg  <= 1'b0;
      mode_reg <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
    end else if (!stall) begin
      val_reg  <= val;
      mode_reg <= mode;
      if (pos) begin
        x_reg <= x - y_sh;
        y_reg <= y + x_sh;
        z_reg <= z - ATAN_C;
      end else begin
        x_reg <= x + y_sh;
        y_reg <= y - x_sh;
        z_reg <= z + ATAN_C;
      end
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC (rotation / vectoring per sample) with quadrant
// pre-rotation and a global stall.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int DAT_W  = 16,
  parameter int ANG_W  = 16,
  parameter int STAGES = 14
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic                     Stall_i,
  input  logic                     Val_i,
  input  logic                     Mode_i,
  input  logic signed [DAT_W-1:0]  X_i,
  input  logic signed [DAT_W-1:0]  Y_i,
  input  logic signed [ANG_W-1:0]  Z_i,
  output logic                     Val_o,
  output logic                     Mode_o,
  output logic signed [DAT_W+1:0]  X_o,
  output logic signed [DAT_W+1:0]  Y_o,
  output logic signed [ANG_W-1:0]  Z_o
);

  localparam int IW = iw_of(DAT_W);

  logic signed [IW-1:0]    x_ext;
  logic signed [IW-1:0]    y_ext;
  logic                    flip;
  logic                    p_val_reg;
  logic                    p_mode_reg;
  logic signed [IW-1:0]    p_x_reg;
  logic signed [IW-1:0]    p_y_reg;
  logic signed [ANG_W-1:0] p_z_reg;

  logic [STAGES:0]            val_c;
  logic [STAGES:0]            mode_c;
  logic [STAGES:0][IW-1:0]    x_c;
  logic [STAGES:0][IW-1:0]    y_c;
  logic [STAGES:0][ANG_W-1:0] z_c;

  assign x_ext = {{(IW-DAT_W){X_i[DAT_W-1]}}, X_i};
  assign y_ext = {{(IW-DAT_W){Y_i[DAT_W-1]}}, Y_i};
  // Move the vector into the right half-plane so the iterations converge
  assign flip  = (Mode_i == VEC) ? X_i[DAT_W-1] : (Z_i[ANG_W-1] ^ Z_i[ANG_W-2]);

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      p_val_reg  <= 1'b0;
      p_mode_reg <= 1'b0;
      p_x_reg    <= '0;
      p_y_reg    <= '0;
      p_z_reg    <= '0;
    end else if (!Stall_i) begin
      p_val_reg  <= Val_i;
      p_mode_reg <= Mode_i;
      if (flip) begin
        p_x_reg <= -x_ext;
        p_y_reg <= -y_ext;
        p_z_reg <= {~Z_i[ANG_W-1], Z_i[ANG_W-2:0]};
      end else begin
        p_x_reg <= x_ext;
        p_y_reg <= y_ext;
        p_z_reg <= Z_i;
      end
    end
  end

  assign val_c[0]  = p_val_reg;
  assign mode_c[0] = p_mode_reg;
  assign x_c[0]    = p_x_reg;
  assign y_c[0]    = p_y_reg;
  assign z_c[0]    = p_z_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      cordic_stage #(
        .IW       (IW),
        .ANG_W    (ANG_W),
        .SHIFT    (gi),
        .ATAN_VAL (atan_val(ANG_W, gi))
      ) u_stage (
        .clk      (Clk_i),
        .rst      (Rst_i),
        .stall    (Stall_i),
        .val      (val_c[gi]),
        .mode     (mode_c[gi]),
        .x        (x_c[gi]),
        .y        (y_c[gi]),
        .z        (z_c[gi]),
        .val_reg  (val_c[gi+1]),
        .mode_reg (mode_c[gi+1]),
        .x_reg    (x_c[gi+1]),
        .y_reg    (y_c[gi+1]),
        .z_reg    (z_c[gi+1])
      );
    end
  endgenerate

  assign Val_o  = val_c[STAGES];
  assign Mode_o = mode_c[STAGES];
  assign X_o    = x_c[STAGES];
  assign Y_o    = y_c[STAGES];
  assign Z_o    = z_c[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: directed vectors with hand-computed
// results, back-to-back mixed modes, stall freeze and async reset mid-stream.
module tb_cordic_pipe;
  import cordic_pkg::*;

  localparam int DAT_W  = 16;
  localparam int ANG_W  = 16;
  localparam int STAGES = 14;
  localparam int LAT    = STAGES + 1;
  localparam int XY_TOL = 4;
  localparam int Z_TOL  = 2;

  logic                    clk = 1'b0;
  logic                    Rst_i, Stall_i, Val_i, Mode_i;
  logic signed [DAT_W-1:0] X_i, Y_i;
  logic signed [ANG_W-1:0] Z_i;
  logic                    Val_o, Mode_o;
  logic signed [DAT_W+1:0] X_o, Y_o;
  logic signed [ANG_W-1:0] Z_o;

  always #5 clk = ~clk;

  cordic_pipe #(.DAT_W(DAT_W), .ANG_W(ANG_W), .STAGES(STAGES)) dut (
    .Clk_i(clk), .Rst_i(Rst_i), .Stall_i(Stall_i), .Val_i(Val_i), .Mode_i(Mode_i),
    .X_i(X_i), .Y_i(Y_i), .Z_i(Z_i),
    .Val_o(Val_o), .Mode_o(Mode_o), .X_o(X_o), .Y_o(Y_o), .Z_o(Z_o)
  );

  typedef struct {
    int mode; int x; int y; int z; int ex; int ey; int ez;
  } vec_t;

  typedef struct {
    int mode; int ex; int ey; int ez; int act; int wall; int exp_wall; int idx;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   act_cnt = 0;
  int   wall_cnt = 0;
  bit   last_adv = 1'b0;
  int   n_out = 0;

  always @(posedge clk) begin
    wall_cnt <= wall_cnt + 1;
    last_adv <= !Stall_i && !Rst_i;
    if (!Stall_i && !Rst_i) act_cnt <= act_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp, input int tol, input bit wrap);
    int d;
    logic signed [ANG_W-1:0] dw;
    checks++;
    d = act - exp;
    if (wrap) begin
      dw = d[ANG_W-1:0];
      d  = int'(dw);
    end
    if (d <= tol && d >= -tol) passed++;
    else $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
  endtask

  // Monitor: consume one expected entry per newly presented valid output
  always @(negedge clk) begin : mon
    exp_t e;
    if (last_adv && Val_o) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_valid: got Val_o=1 x=%0d, want no output pending", X_o);
      end else begin
        e = sb.pop_front();
        $display("out %0d: vec=%0d mode=%0d x=%0d y=%0d z=%0d", n_out, e.idx, Mode_o, X_o, Y_o, Z_o);
        n_out++;
        check("mode", int'(Mode_o), e.mode, 0, 1'b0);
        check("x_o", int'(X_o), e.ex, XY_TOL, 1'b0);
        check("y_o", int'(Y_o), e.ey, XY_TOL, 1'b0);
        check("z_o", int'(Z_o), e.ez, Z_TOL, 1'b1);
        check("latency", act_cnt - e.act, LAT, 0, 1'b0);
        check("wall_latency", wall_cnt - e.wall, e.exp_wall, 0, 1'b0);
      end
    end
  end

  task automatic drive(input int idx, input int exp_wall);
    exp_t e;
    Val_i  = 1'b1;
    Mode_i = tbl[idx].mode[0];
    X_i    = DAT_W'(tbl[idx].x);
    Y_i    = DAT_W'(tbl[idx].y);
    Z_i    = ANG_W'(tbl[idx].z);
    e.mode = tbl[idx].mode;
    e.ex = tbl[idx].ex; e.ey = tbl[idx].ey; e.ez = tbl[idx].ez;
    e.act = act_cnt; e.wall = wall_cnt; e.exp_wall = exp_wall; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    Val_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int snap_val, snap_x, snap_y, snap_z;

  initial begin
    //          mode x       y      z       ex      ey      ez
    tbl[0] = '{0, 10000,  0,     0,      16468,  0,      0};
    tbl[1] = '{0, 10000,  0,     16384,  0,      16468,  0};
    tbl[2] = '{0, 10000,  0,    -24576, -11644, -11644,  0};
    tbl[3] = '{0, 0,     -8000,  8192,   9316,  -9316,   0};
    tbl[4] = '{1, 3000,   4000,  0,      8234,   0,      9672};
    tbl[5] = '{1, -10000, 0,     0,      16468,  0,     -32768};
    tbl[6] = '{1, 0,      10000, 0,      16468,  0,      16384};
    tbl[7] = '{1, -5000, -5000,  0,      11644,  0,     -24576};
    tbl[8] = '{1, 3000,   4000, -16384,  8234,   0,     -6712};

    Rst_i = 1'b1; Stall_i = 1'b0; Val_i = 1'b0; Mode_i = 1'b0;
    X_i = '0; Y_i = '0; Z_i = '0;
    repeat (3) @(negedge clk);
    check("reset_val", int'(Val_o), 0, 0, 1'b0);
    check("reset_mode", int'(Mode_o), 0, 0, 1'b0);
    check("reset_x", int'(X_o), 0, 0, 1'b0);
    check("reset_y", int'(Y_o), 0, 0, 1'b0);
    check("reset_z", int'(Z_o), 0, 0, 1'b0);
    Rst_i = 1'b0;
    @(negedge clk);

    // Isolated directed vectors
    for (int i = 0; i < 9; i++) begin
      drive(i, LAT);
      idle(LAT + 2);
    end

    // Alternating ROT/VEC every clock
    for (int k = 0; k < 32; k++)
      drive((k % 2 == 0) ? (k / 2) % 4 : 4 + (k / 2) % 5, LAT);
    idle(LAT + 2);

    // Stall for 5 cycles with outputs flowing; samples 4..17 straddle it
    for (int j = 0; j < 18; j++)
      drive(j % 9, (j >= 4) ? LAT + 5 : LAT);
    snap_val = int'(Val_o); snap_x = int'(X_o); snap_y = int'(Y_o); snap_z = int'(Z_o);
    Stall_i = 1'b1; Val_i = 1'b1; Mode_i = 1'b1; X_i = 16'sd1234; Y_i = -16'sd77; Z_i = 16'sd999;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_hold_val", int'(Val_o), snap_val, 0, 1'b0);
      check("stall_hold_x", int'(X_o), snap_x, 0, 1'b0);
      check("stall_hold_y", int'(Y_o), snap_y, 0, 1'b0);
      check("stall_hold_z", int'(Z_o), snap_z, 0, 1'b0);
    end
    Stall_i = 1'b0;
    drive(0, LAT);
    drive(5, LAT);
    idle(LAT + 2);

    // Async reset between edges with 8 samples in flight
    for (int j = 0; j < 3; j++) drive(j, LAT);
    idle(6);
    for (int j = 0; j < 8; j++) drive(4 + j % 5, LAT);
    Val_i = 1'b0;
    check("pre_reset_val", int'(Val_o), 1, 0, 1'b0);
    #2;
    Rst_i = 1'b1;
    #1;
    check("async_reset_val", int'(Val_o), 0, 0, 1'b0);
    check("async_reset_mode", int'(Mode_o), 0, 0, 1'b0);
    check("async_reset_x", int'(X_o), 0, 0, 1'b0);
    check("async_reset_y", int'(Y_o), 0, 0, 1'b0);
    check("async_reset_z", int'(Z_o), 0, 0, 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    Rst_i = 1'b0;
    idle(LAT + 5);
    drive(4, LAT);
    drive(2, LAT);
    idle(LAT + 2);

    for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      checks += sb.size();
      $display("FAIL drain: got %0d outputs missing, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
